// File: rtl/acc_fifo_pair_pkg.sv
// Shared sizing for the accelerator-side FIFO pair.
//   WIDTH : data word width
//   DEPTH : words per FIFO (power of two, >= 2)
//   PTR_W : pointer width; one extra MSB acts as the wrap bit
package acc_fifo_pair_pkg;
  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int PTR_W = $clog2(DEPTH) + 1;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with flush and sticky error flags.
// Ports:
//   clk, reset (async, active-low), flush (sync clear of pointers/flags)
//   push, push_data         : write side; a push while full is dropped
//   pop, pop_data, pop_valid: read side; head word registered on a good pop
//   empty, full             : decoded from the registered pointers
//   overflow, underflow     : sticky, cleared by reset or flush
module sync_fifo
  import acc_fifo_pair_pkg::*;
#(
  parameter int WIDTH = acc_fifo_pair_pkg::WIDTH,
  parameter int DEPTH = acc_fifo_pair_pkg::DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             pop_valid,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Full when the slot indices match but the wrap bits differ.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;

  // Storage carries no reset; only pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  // Pop stage: head word is registered to pop_data, flags settle on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      pop_data  <= '0;
      pop_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      // pop_data deliberately holds its last value across a flush.
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      pop_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      pop_valid <= pop_ok;
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (push && full) begin
        overflow <= 1'b1;
      end
      if (pop_ok) begin
        pop_data <= mem[rd_ptr[AW-1:0]];
        rd_ptr   <= rd_ptr + PW'(1);
      end
      if (pop && empty) begin
        underflow <= 1'b1;
      end
    end
  end
endmodule

// File: rtl/acc_fifo_pair.sv
// FIFO pair between the data/control router and one accelerator core.
// Ports:
//   clk, reset (async, active-low), flush (sync clear of both FIFOs)
//   put_req/put_data, to_empty/to_full          : router -> to-acc FIFO
//   acc_pop, acc_data_out, acc_valid            : accelerator reads to-acc FIFO
//   acc_push/acc_data_in                        : accelerator -> from-acc FIFO
//   get_req, get_data, from_empty/from_full     : router reads from-acc FIFO
//   to_/from_overflow, to_/from_underflow       : sticky error flags
module acc_fifo_pair
  import acc_fifo_pair_pkg::*;
#(
  parameter int WIDTH = acc_fifo_pair_pkg::WIDTH,
  parameter int DEPTH = acc_fifo_pair_pkg::DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             put_req,
  input  logic [WIDTH-1:0] put_data,
  output logic             to_empty,
  output logic             to_full,
  input  logic             acc_pop,
  output logic [WIDTH-1:0] acc_data_out,
  output logic             acc_valid,
  input  logic             acc_push,
  input  logic [WIDTH-1:0] acc_data_in,
  input  logic             get_req,
  output logic [WIDTH-1:0] get_data,
  output logic             from_empty,
  output logic             from_full,
  output logic             to_overflow,
  output logic             from_overflow,
  output logic             to_underflow,
  output logic             from_underflow
);
  // The router has no valid strobe on the return path; it relies on from_empty.
  logic get_valid_unused;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_to_acc (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (put_req),
    .push_data (put_data),
    .pop       (acc_pop),
    .pop_data  (acc_data_out),
    .pop_valid (acc_valid),
    .empty     (to_empty),
    .full      (to_full),
    .overflow  (to_overflow),
    .underflow (to_underflow)
  );

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_from_acc (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (acc_push),
    .push_data (acc_data_in),
    .pop       (get_req),
    .pop_data  (get_data),
    .pop_valid (get_valid_unused),
    .empty     (from_empty),
    .full      (from_full),
    .overflow  (from_overflow),
    .underflow (from_underflow)
  );
endmodule

// File: tb/tb_acc_fifo_pair.sv
module tb_acc_fifo_pair;
  localparam int W     = 32;
  localparam int DEPTH = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic         put_req;
  logic [W-1:0] put_data;
  logic         to_empty, to_full;
  logic         acc_pop;
  logic [W-1:0] acc_data_out;
  logic         acc_valid;
  logic         acc_push;
  logic [W-1:0] acc_data_in;
  logic         get_req;
  logic [W-1:0] get_data;
  logic         from_empty, from_full;
  logic         to_overflow, from_overflow, to_underflow, from_underflow;

  acc_fifo_pair dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .put_req        (put_req),
    .put_data       (put_data),
    .to_empty       (to_empty),
    .to_full        (to_full),
    .acc_pop        (acc_pop),
    .acc_data_out   (acc_data_out),
    .acc_valid      (acc_valid),
    .acc_push       (acc_push),
    .acc_data_in    (acc_data_in),
    .get_req        (get_req),
    .get_data       (get_data),
    .from_empty     (from_empty),
    .from_full      (from_full),
    .to_overflow    (to_overflow),
    .from_overflow  (from_overflow),
    .to_underflow   (to_underflow),
    .from_underflow (from_underflow)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Reference model: queues hold the expected contents of each FIFO.
  logic [W-1:0] q_to[$];
  logic [W-1:0] q_from[$];
  logic [W-1:0] m_acc_data, m_get_data;
  logic         m_acc_valid;
  logic         m_to_ovf, m_to_udf, m_from_ovf, m_from_udf;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q_to.delete();
    q_from.delete();
    m_acc_data  = '0;
    m_get_data  = '0;
    m_acc_valid = 1'b0;
    m_to_ovf    = 1'b0;
    m_to_udf    = 1'b0;
    m_from_ovf  = 1'b0;
    m_from_udf  = 1'b0;
  endtask

  task automatic check_all();
    chk("to_empty",       to_empty,       q_to.size() == 0);
    chk("to_full",        to_full,        q_to.size() == DEPTH);
    chk("from_empty",     from_empty,     q_from.size() == 0);
    chk("from_full",      from_full,      q_from.size() == DEPTH);
    chk("acc_valid",      acc_valid,      m_acc_valid);
    chk("acc_data_out",   acc_data_out,   m_acc_data);
    chk("get_data",       get_data,       m_get_data);
    chk("to_overflow",    to_overflow,    m_to_ovf);
    chk("to_underflow",   to_underflow,   m_to_udf);
    chk("from_overflow",  from_overflow,  m_from_ovf);
    chk("from_underflow", from_underflow, m_from_udf);
  endtask

  task automatic idle_inputs();
    flush = 0; put_req = 0; put_data = '0; acc_pop = 0;
    acc_push = 0; acc_data_in = '0; get_req = 0;
  endtask

  // One clock of stimulus: expectations are queued/popped here, outputs checked after the edge.
  task automatic cycle(input logic put, input logic [W-1:0] pd, input logic apop,
                       input logic apush, input logic [W-1:0] ad, input logic get,
                       input logic fl);
    int to_n, from_n;
    put_req = put; put_data = pd; acc_pop = apop;
    acc_push = apush; acc_data_in = ad; get_req = get; flush = fl;
    to_n   = q_to.size();
    from_n = q_from.size();
    m_acc_valid = 1'b0;
    if (fl) begin
      q_to.delete();
      q_from.delete();
      m_to_ovf = 0; m_to_udf = 0; m_from_ovf = 0; m_from_udf = 0;
    end else begin
      if (apop) begin
        if (to_n > 0) begin m_acc_data = q_to.pop_front(); m_acc_valid = 1'b1; end
        else m_to_udf = 1'b1;
      end
      if (put) begin
        if (to_n < DEPTH) q_to.push_back(pd);
        else m_to_ovf = 1'b1;
      end
      if (get) begin
        if (from_n > 0) m_get_data = q_from.pop_front();
        else m_from_udf = 1'b1;
      end
      if (apush) begin
        if (from_n < DEPTH) q_from.push_back(ad);
        else m_from_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    idle_inputs();
    check_all();
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // Fill to full, overflow, drain in order.
    for (int i = 1; i <= DEPTH; i++) cycle(1, W'(i), 0, 0, '0, 0, 0);
    chk("fill_full", to_full, 1'b1);
    cycle(1, 32'hDEAD, 0, 0, '0, 0, 0);
    chk("fill_ovf", to_overflow, 1'b1);
    for (int i = 1; i <= DEPTH; i++) begin
      cycle(0, '0, 1, 0, '0, 0, 0);
      chk("drain_word", acc_data_out, W'(i));
    end
    chk("drain_empty", to_empty, 1'b1);
    cycle(0, '0, 0, 0, '0, 0, 1);

    // Underflow on the return FIFO keeps the last word.
    cycle(0, '0, 0, 1, 32'h55, 0, 0);
    cycle(0, '0, 0, 0, '0, 1, 0);
    cycle(0, '0, 0, 0, '0, 1, 0);
    chk("udf_hold", get_data, 32'h55);
    chk("udf_flag", from_underflow, 1'b1);
    cycle(0, '0, 0, 0, '0, 0, 0);
    chk("udf_sticky", from_underflow, 1'b1);
    cycle(0, '0, 0, 0, '0, 0, 1);

    // Steady-state streaming across pointer wrap, both directions.
    for (int i = 0; i < 8; i++) cycle(1, 32'h100 + W'(i), 0, 1, 32'h900 + W'(i), 0, 0);
    for (int i = 8; i < 48; i++)
      cycle(1, 32'h100 + W'(i), 1, 1, 32'h900 + W'(i), 1, 0);
    chk("wrap_acc", acc_data_out, 32'h100 + 32'd39);
    chk("wrap_get", get_data, 32'h900 + 32'd39);
    chk("wrap_no_ovf", to_overflow | from_overflow, 1'b0);
    cycle(0, '0, 0, 0, '0, 0, 1);

    // Full-boundary push+pop on the return FIFO.
    for (int i = 0; i < DEPTH; i++) cycle(0, '0, 0, 1, 32'hA000 + W'(i), 0, 0);
    chk("bnd_full", from_full, 1'b1);
    cycle(0, '0, 0, 1, 32'hFFFF, 1, 0);
    chk("bnd_pop", get_data, 32'hA000);
    chk("bnd_ovf", from_overflow, 1'b1);
    chk("bnd_not_full", from_full, 1'b0);
    cycle(0, '0, 0, 0, '0, 0, 1);

    // Flush beats a same-cycle put.
    for (int i = 0; i < 5; i++) cycle(1, 32'hC0 + W'(i), 0, 0, '0, 0, 0);
    cycle(1, 32'hBEEF, 0, 0, '0, 0, 1);
    chk("flush_empty", to_empty, 1'b1);
    cycle(0, '0, 1, 0, '0, 0, 0);
    chk("flush_udf", to_underflow, 1'b1);

    // Asynchronous reset in the middle of traffic.
    for (int i = 0; i < 4; i++) cycle(1, 32'h77 + W'(i), i > 1, 1, 32'h88, 0, 0);
    cycle(0, '0, 1, 0, '0, 1, 0);
    put_req = 1; put_data = 32'h1234; acc_push = 1; acc_data_in = 32'h5678;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_acc_data", acc_data_out, 32'h0);
    @(posedge clk); #1;
    idle_inputs();
    check_all();
    @(negedge clk);
    reset = 1'b1;
    cycle(1, 32'h42, 0, 0, '0, 0, 0);
    cycle(0, '0, 1, 0, '0, 0, 0);
    chk("post_rst", acc_data_out, 32'h42);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
